// File: rtl/toris_pkg.sv
// Shared types and timing defaults for the Tetris core game-timing blocks.
package toris_pkg;

    localparam int unsigned CNT_W = 11;
    localparam int unsigned RST_W = 4;

    localparam int unsigned DEF_BASE_MS    = 1000;
    localparam int unsigned DEF_STEP_MS    = 75;
    localparam int unsigned DEF_MIN_MS     = 100;
    localparam int unsigned DEF_SOFT_MS    = 50;
    localparam int unsigned DEF_LOCK_MS    = 500;
    localparam int unsigned DEF_MAX_RESETS = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LOCK  = 2'd2,
        PAUSE = 2'd3
    } state_t;

endpackage

// File: rtl/fall_scheduler_if.sv
// Command/status bundle between the fall scheduler and the game core.
// Commands and tick1k are single-cycle strobes; landed/soft_drop/level are levels.
interface fall_scheduler_if;
    import toris_pkg::*;

    logic             tick1k;
    logic [3:0]       level;
    logic             soft_drop;
    logic             landed;
    logic             moved;
    logic             start;
    logic             pause_tgl;
    logic             game_over;
    logic             fall_step;
    logic             lock_now;
    logic             running;
    logic             paused;
    logic [CNT_W-1:0] period_ms;
    state_t           dbg_state;

    modport master (
        output tick1k, level, soft_drop, landed, moved, start, pause_tgl, game_over,
        input  fall_step, lock_now, running, paused, period_ms, dbg_state
    );

    modport slave (
        input  tick1k, level, soft_drop, landed, moved, start, pause_tgl, game_over,
        output fall_step, lock_now, running, paused, period_ms, dbg_state
    );

endinterface

// File: rtl/fall_scheduler_period_calc.sv
// Combinational gravity period: level-scaled, floored at MIN_MS, capped by soft drop.
module fall_period_calc
    import toris_pkg::*;
#(
    parameter int unsigned BASE_MS = DEF_BASE_MS,
    parameter int unsigned STEP_MS = DEF_STEP_MS,
    parameter int unsigned MIN_MS  = DEF_MIN_MS,
    parameter int unsigned SOFT_MS = DEF_SOFT_MS
) (
    input  logic [3:0]       level_i,
    input  logic             soft_drop_i,
    output logic [CNT_W-1:0] period_o
);

    logic [15:0]      drop;
    logic [CNT_W-1:0] normal;

    assign drop = 16'(level_i) * 16'(STEP_MS);

    // Compare before subtracting so high levels can never wrap below MIN_MS.
    always_comb begin
        normal = CNT_W'(MIN_MS);
        if (drop < 16'(BASE_MS - MIN_MS)) begin
            normal = CNT_W'(BASE_MS) - CNT_W'(drop);
        end
        period_o = normal;
        if (soft_drop_i && (normal > CNT_W'(SOFT_MS))) begin
            period_o = CNT_W'(SOFT_MS);
        end
    end

endmodule

// File: rtl/fall_scheduler.sv
// Gravity and lock-delay timer for the Tetris core, driven by the 1 ms strobe.
// Optional lock-timer reset on player moves: FALL_SCHED_LOCK_RESET_EN.
module fall_scheduler
    import toris_pkg::*;
#(
    parameter int unsigned BASE_MS = DEF_BASE_MS,
    parameter int unsigned STEP_MS = DEF_STEP_MS,
    parameter int unsigned MIN_MS  = DEF_MIN_MS,
    parameter int unsigned SOFT_MS = DEF_SOFT_MS,
    parameter int unsigned LOCK_MS = DEF_LOCK_MS
`ifdef FALL_SCHED_LOCK_RESET_EN
    , parameter int unsigned MAX_RESETS = DEF_MAX_RESETS
`endif
) (
    input  logic              clk50,
    input  logic              rst_n,
    fall_scheduler_if.slave   bus
);

    state_t           state_q;
    state_t           resume_state_q;
    logic [CNT_W-1:0] ms_cnt_q;
    logic [CNT_W-1:0] lock_cnt_q;
    logic [CNT_W-1:0] period_ms_q;
    logic [CNT_W-1:0] period_d;
    logic             fall_step_q;
    logic             lock_now_q;
    logic             running_q;
    logic             paused_q;
`ifdef FALL_SCHED_LOCK_RESET_EN
    logic [RST_W-1:0] reset_cnt_q;
`else
    logic             unused_moved;
    assign unused_moved = bus.moved;
`endif

    fall_period_calc #(
        .BASE_MS (BASE_MS),
        .STEP_MS (STEP_MS),
        .MIN_MS  (MIN_MS),
        .SOFT_MS (SOFT_MS)
    ) u_period (
        .level_i     (bus.level),
        .soft_drop_i (bus.soft_drop),
        .period_o    (period_d)
    );

    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            resume_state_q <= RUN;
            ms_cnt_q       <= '0;
            lock_cnt_q     <= '0;
            period_ms_q    <= CNT_W'(BASE_MS);
            fall_step_q    <= 1'b0;
            lock_now_q     <= 1'b0;
            running_q      <= 1'b0;
            paused_q       <= 1'b0;
`ifdef FALL_SCHED_LOCK_RESET_EN
            reset_cnt_q    <= '0;
`endif
        end else begin
            fall_step_q <= 1'b0;
            lock_now_q  <= 1'b0;
            period_ms_q <= period_d;
            if (bus.game_over) begin
                state_q    <= IDLE;
                ms_cnt_q   <= '0;
                lock_cnt_q <= '0;
                running_q  <= 1'b0;
                paused_q   <= 1'b0;
`ifdef FALL_SCHED_LOCK_RESET_EN
                reset_cnt_q <= '0;
`endif
            end else if (bus.start) begin
                state_q    <= RUN;
                ms_cnt_q   <= '0;
                lock_cnt_q <= '0;
                running_q  <= 1'b1;
                paused_q   <= 1'b0;
`ifdef FALL_SCHED_LOCK_RESET_EN
                reset_cnt_q <= '0;
`endif
            end else if (bus.pause_tgl && (state_q != IDLE)) begin
                if (state_q == PAUSE) begin
                    state_q   <= resume_state_q;
                    running_q <= 1'b1;
                    paused_q  <= 1'b0;
                end else begin
                    resume_state_q <= state_q;
                    state_q        <= PAUSE;
                    running_q      <= 1'b0;
                    paused_q       <= 1'b1;
                end
            end else begin
                case (state_q)
                    RUN: begin
                        if (bus.landed) begin
                            state_q    <= LOCK;
                            lock_cnt_q <= '0;
                        end else if (bus.tick1k) begin
                            // >= so a period shortened mid-count fires on the next tick.
                            if (ms_cnt_q >= period_ms_q - CNT_W'(1)) begin
                                fall_step_q <= 1'b1;
                                ms_cnt_q    <= '0;
                            end else begin
                                ms_cnt_q <= ms_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    LOCK: begin
                        if (!bus.landed) begin
                            state_q  <= RUN;
                            ms_cnt_q <= '0;
`ifdef FALL_SCHED_LOCK_RESET_EN
                        end else if (bus.moved && (32'(reset_cnt_q) < MAX_RESETS)) begin
                            lock_cnt_q  <= '0;
                            reset_cnt_q <= reset_cnt_q + RST_W'(1);
`endif
                        end else if (bus.tick1k) begin
                            if (lock_cnt_q == CNT_W'(LOCK_MS - 1)) begin
                                lock_now_q <= 1'b1;
                                state_q    <= RUN;
                                ms_cnt_q   <= '0;
`ifdef FALL_SCHED_LOCK_RESET_EN
                                reset_cnt_q <= '0;
`endif
                            end else begin
                                lock_cnt_q <= lock_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.fall_step = fall_step_q;
    assign bus.lock_now  = lock_now_q;
    assign bus.running   = running_q;
    assign bus.paused    = paused_q;
    assign bus.period_ms = period_ms_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_fall_scheduler.sv
// Directed bench for fall_scheduler: gravity timing, lock delay, pause, commands, reset.
module tb_fall_scheduler;
    import toris_pkg::*;

    logic clk50;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   fs_cnt;
    int   lk_cnt;
    int   unpaused_cnt;
    int   overlap_cnt;

    fall_scheduler_if bus ();

    fall_scheduler dut (
        .clk50 (clk50),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk50 = 1'b0;
    always #5 clk50 = ~clk50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic tk);
        bus.tick1k = tk;
        @(posedge clk50);
        #1;
        if (bus.fall_step) fs_cnt++;
        if (bus.lock_now) lk_cnt++;
        if (bus.fall_step && bus.lock_now) overlap_cnt++;
        if (!bus.paused) unpaused_cnt++;
        bus.tick1k = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    task automatic clr();
        fs_cnt       = 0;
        lk_cnt       = 0;
        unpaused_cnt = 0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step(1'b0);
        bus.start = 1'b0;
    endtask

    task automatic pulse_pause();
        bus.pause_tgl = 1'b1;
        step(1'b0);
        bus.pause_tgl = 1'b0;
    endtask

    task automatic pulse_moved();
        bus.moved = 1'b1;
        step(1'b0);
        bus.moved = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        overlap_cnt = 0;
        clr();
        rst_n         = 1'b0;
        bus.tick1k    = 1'b0;
        bus.level     = 4'd0;
        bus.soft_drop = 1'b0;
        bus.landed    = 1'b0;
        bus.moved     = 1'b0;
        bus.start     = 1'b0;
        bus.pause_tgl = 1'b0;
        bus.game_over = 1'b0;
        repeat (3) step(1'b0);
        check("rst_fall_step", 32'(bus.fall_step), 0);
        check("rst_lock_now", 32'(bus.lock_now), 0);
        check("rst_running", 32'(bus.running), 0);
        check("rst_paused", 32'(bus.paused), 0);
        check("rst_period", 32'(bus.period_ms), 1000);
        check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        step(1'b0);

        clr();
        ticks(50);
        check("idle_no_fall", 32'(fs_cnt), 0);
        pulse_pause();
        check("idle_pause_ignored", 32'(bus.paused), 0);
        check("idle_pause_state", 32'(bus.dbg_state), 32'(IDLE));

        // Level 0 gravity: first step right after the 1000th tick, then periodic.
        pulse_start();
        check("start_running", 32'(bus.running), 1);
        check("start_state", 32'(bus.dbg_state), 32'(RUN));
        check("lvl0_period", 32'(bus.period_ms), 1000);
        clr();
        ticks(999);
        check("lvl0_no_early_fall", 32'(fs_cnt), 0);
        ticks(1);
        check("lvl0_fall_at_1000", 32'(bus.fall_step), 1);
        step(1'b0);
        check("fall_one_cycle", 32'(bus.fall_step), 0);
        clr();
        ticks(1000);
        check("lvl0_periodic_cnt", 32'(fs_cnt), 1);
        check("lvl0_periodic_edge", 32'(bus.fall_step), 1);

        // Shortened period fires on the very next tick.
        ticks(200);
        bus.level = 4'd12;
        step(1'b0);
        check("lvl12_period", 32'(bus.period_ms), 100);
        step(1'b1);
        check("shorten_fires_now", 32'(bus.fall_step), 1);
        bus.level = 4'd15;
        step(1'b0);
        check("lvl15_period", 32'(bus.period_ms), 100);
        bus.level = 4'd11;
        step(1'b0);
        check("lvl11_period", 32'(bus.period_ms), 175);
        bus.level = 4'd1;
        step(1'b0);
        check("lvl1_period", 32'(bus.period_ms), 925);
        bus.soft_drop = 1'b1;
        step(1'b0);
        check("lvl1_soft_period", 32'(bus.period_ms), 50);
        bus.level = 4'd0;
        step(1'b0);
        check("lvl0_soft_period", 32'(bus.period_ms), 50);
        pulse_start();
        clr();
        ticks(49);
        check("soft_no_early", 32'(fs_cnt), 0);
        ticks(1);
        check("soft_fall_at_50", 32'(bus.fall_step), 1);
        clr();
        ticks(100);
        check("soft_periodic_cnt", 32'(fs_cnt), 2);
        bus.soft_drop = 1'b0;
        step(1'b0);
        check("soft_release_period", 32'(bus.period_ms), 1000);

        // Lock delay.
        pulse_start();
        bus.landed = 1'b1;
        step(1'b0);
        check("landed_state", 32'(bus.dbg_state), 32'(LOCK));
        check("landed_running", 32'(bus.running), 1);
        clr();
        ticks(499);
        check("lock_no_early", 32'(lk_cnt), 0);
        ticks(1);
        check("lock_at_500", 32'(bus.lock_now), 1);
        check("lock_no_fall", 32'(fs_cnt), 0);
        check("lock_back_run", 32'(bus.dbg_state), 32'(RUN));
        step(1'b0);
        check("lock_one_cycle", 32'(bus.lock_now), 0);

        // Slide off after 200 ms of lock: no lock, gravity restarts from zero.
        pulse_start();
        step(1'b0);
        clr();
        ticks(200);
        bus.landed = 1'b0;
        step(1'b0);
        check("slide_state", 32'(bus.dbg_state), 32'(RUN));
        ticks(1000);
        check("slide_no_lock", 32'(lk_cnt), 0);
        check("slide_fall_cnt", 32'(fs_cnt), 1);
        check("slide_fall_edge", 32'(bus.fall_step), 1);

        // Player moves while landed.
        pulse_start();
        bus.landed = 1'b1;
        step(1'b0);
        clr();
`ifdef FALL_SCHED_LOCK_RESET_EN
        for (int r = 0; r < 15; r++) begin
            ticks(400);
            pulse_moved();
        end
        check("reset15_no_lock", 32'(lk_cnt), 0);
        ticks(400);
        pulse_moved();
        ticks(99);
        check("reset16_ignored_wait", 32'(lk_cnt), 0);
        ticks(1);
        check("reset_lock_after_500", 32'(bus.lock_now), 1);
`else
        ticks(300);
        pulse_moved();
        ticks(199);
        check("moved_ignored_wait", 32'(lk_cnt), 0);
        ticks(1);
        check("moved_ignored_lock", 32'(bus.lock_now), 1);
`endif
        bus.landed = 1'b0;
        step(1'b0);

        // Pause holds the gravity count.
        pulse_start();
        clr();
        ticks(400);
        pulse_pause();
        check("pause_paused", 32'(bus.paused), 1);
        check("pause_running", 32'(bus.running), 0);
        check("pause_state", 32'(bus.dbg_state), 32'(PAUSE));
        clr();
        ticks(300);
        check("pause_no_fall", 32'(fs_cnt), 0);
        check("pause_held", 32'(unpaused_cnt), 0);
        pulse_pause();
        check("resume_state", 32'(bus.dbg_state), 32'(RUN));
        check("resume_running", 32'(bus.running), 1);
        clr();
        ticks(599);
        check("resume_no_early", 32'(fs_cnt), 0);
        ticks(1);
        check("resume_fall_at_600", 32'(bus.fall_step), 1);

        bus.landed = 1'b1;
        step(1'b0);
        pulse_pause();
        pulse_pause();
        check("resume_to_lock", 32'(bus.dbg_state), 32'(LOCK));

        // game_over outranks start.
        bus.start     = 1'b1;
        bus.game_over = 1'b1;
        step(1'b0);
        bus.start     = 1'b0;
        bus.game_over = 1'b0;
        check("gameover_state", 32'(bus.dbg_state), 32'(IDLE));
        check("gameover_running", 32'(bus.running), 0);

        // Reset mid-LOCK on the cycle the lock would expire.
        bus.level = 4'd5;
        pulse_start();
        step(1'b0);
        check("lvl5_period", 32'(bus.period_ms), 625);
        ticks(499);
        rst_n = 1'b0;
        step(1'b1);
        check("midrst_lock_now", 32'(bus.lock_now), 0);
        check("midrst_fall_step", 32'(bus.fall_step), 0);
        check("midrst_running", 32'(bus.running), 0);
        check("midrst_paused", 32'(bus.paused), 0);
        check("midrst_period", 32'(bus.period_ms), 1000);
        check("midrst_state", 32'(bus.dbg_state), 32'(IDLE));
        rst_n      = 1'b1;
        bus.landed = 1'b0;
        bus.level  = 4'd0;
        step(1'b0);

        check("no_pulse_overlap", 32'(overlap_cnt), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
